// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W   = 8;
  localparam int REGFILE_NUM_REGS = 4;
  localparam int REGFILE_NUM_RD   = 2;

  // Widest word the byte-merge helper handles; callers cast to their own width.
  localparam int REGFILE_MAX_W  = 256;
  localparam int REGFILE_MAX_BE = REGFILE_MAX_W / 8;

  function automatic int rf_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int rf_addr_w(input int num_regs);
    return (rf_clog2(num_regs) < 1) ? 1 : rf_clog2(num_regs);
  endfunction

  function automatic logic [REGFILE_MAX_W-1:0] rf_byte_merge(
    input logic [REGFILE_MAX_W-1:0]  old_v,
    input logic [REGFILE_MAX_W-1:0]  new_v,
    input logic [REGFILE_MAX_BE-1:0] be
  );
    logic [REGFILE_MAX_W-1:0] r;
    r = old_v;
    for (int k = 0; k < REGFILE_MAX_BE; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read lane: range check, optional write bypass (REGFILE_BYPASS_EN),
// rd_data/rd_valid registers and a combinational per-lane error bit.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = REGFILE_DATA_W,
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  logic              in_range;
  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign in_range = int'(rd_addr) < NUM_REGS;
  assign stored   = in_range ? regs[rd_addr] : '0;

`ifdef REGFILE_BYPASS_EN
  // A same-edge write or clear is forwarded so the lane sees the post-edge contents.
  always_comb begin
    rd_data_d = stored;
    if (clr) begin
      rd_data_d = '0;
    end else if (wr_en && in_range && (wr_addr == rd_addr)) begin
      rd_data_d = DATA_W'(rf_byte_merge(REGFILE_MAX_W'(stored), REGFILE_MAX_W'(wr_data),
                                        REGFILE_MAX_BE'(wr_be)));
    end
  end
`else
  logic bypass_unused;
  assign bypass_unused = ^{clr, wr_en, wr_addr, wr_data, wr_be};

  always_comb begin
    rd_data_d = stored;
  end
`endif

  assign rd_err = rd_en && !in_range;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/regfile_multiport.sv
// Register file: one byte-enabled write port, NUM_RD registered read ports, sync clear.
// Build with REGFILE_BYPASS_EN to forward same-edge writes/clears to the read lanes.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = REGFILE_DATA_W,
  parameter  int NUM_REGS = REGFILE_NUM_REGS,
  parameter  int NUM_RD   = REGFILE_NUM_RD,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [BE_W-1:0]          wr_be,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     addr_err
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_in_range;
  logic [NUM_RD-1:0] rd_err;
  logic              addr_err_d;
  logic              addr_err_q;

  assign wr_in_range = int'(wr_addr) < NUM_REGS;

  // Clear wins over a same-cycle write; out-of-range writes are dropped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
    end else if (wr_en && wr_in_range) begin
      regs_d[wr_addr] = DATA_W'(rf_byte_merge(REGFILE_MAX_W'(regs_q[wr_addr]),
                                              REGFILE_MAX_W'(wr_data),
                                              REGFILE_MAX_BE'(wr_be)));
    end
  end

  assign addr_err_d = (wr_en && !wr_in_range) || (|rd_err);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      addr_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_rdport (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clr      (clr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .regs     (regs_q),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[p]),
      .rd_err   (rd_err[p])
    );
  end

endmodule
